mole_slot_picker: RTL and testbench

Consumer of the 12-bit LFSR random word. On each spawn request it turns the word into a slot index in `[0, NUM_SLOTS)` and drives that slot active for a bounded lifetime. It then reports the outcome as a hit (the matching button was pressed) or a miss (the lifetime expired). It sits between the random generator and the game/score logic, in the same clock domain as the generator.

---
 rtl/mole_slot_picker_pkg.sv | 23 ++
 rtl/life_timer.sv | 27 ++
 rtl/mole_slot_picker.sv | 128 ++++++++++++
 tb/tb_mole_slot_picker.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_slot_picker_pkg.sv
// Shared game definitions: picker state encoding and datapath widths.
// Used by the slot picker and its timed helpers.
package mole_slot_picker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  localparam int SLOT_W = 4;
  localparam int LIFE_W = 24;

  function automatic logic [SLOT_W-1:0] next_slot(
    input logic [SLOT_W-1:0] last,
    input logic              valid,
    input logic [SLOT_W-1:0] top
  );
    if (!valid || last == top) return '0;
    return last + SLOT_W'(1);
  endfunction

endpackage

// File: rtl/life_timer.sv
// Loadable up-counter with a terminal-count flag.
// Shared by timed game elements.
module life_timer #(
  parameter int               WIDTH    = 24,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/mole_slot_picker.sv
// Turns the LFSR word into a non-repeating slot pick and times its life.
// Reports each spawn as a hit or a miss.
module mole_slot_picker
  import mole_slot_picker_pkg::*;
#(
  parameter int NUM_SLOTS   = 9,
  parameter int LIFE_CYCLES = 1000,
  parameter int MAX_DRAWS   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [11:0]          rand_in,
  input  logic                 start,
  input  logic [NUM_SLOTS-1:0] hit,
  output logic                 active,
  output logic [SLOT_W-1:0]    slot_idx,
  output logic [NUM_SLOTS-1:0] slot_onehot,
  output logic                 busy,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  localparam logic [NUM_SLOTS-1:0] ONE = NUM_SLOTS'(1);

  state_t              state;
  logic                prime;
  logic                last_valid;
  logic [SLOT_W-1:0]   cand;
  logic [SLOT_W-1:0]   last_idx;
  logic [SLOT_W-1:0]   pick;
  logic [3:0]          draws;
  logic                fits;
  logic                fresh;
  logic                fallback;
  logic                take;
  logic                hit_now;
  logic                life_tc;
  logic [LIFE_W-1:0]   life_cnt;
  logic                unused_bits;

  assign unused_bits = ^{rand_in[11:4], life_cnt};

  // Candidate is registered, so a DRAW decision uses the previous edge's word.
  always_ff @(posedge clk) begin
    if (!rst_n) cand <= '0;
    else        cand <= rand_in[3:0];
  end

  always_comb begin
    fits     = {1'b0, cand} < 5'(NUM_SLOTS);
    fresh    = !last_valid || (cand != last_idx);
    fallback = (draws == 4'(MAX_DRAWS));
    take     = (state == ST_DRAW) && !prime
             && (fallback || (fits && fresh));
    pick     = fallback
             ? next_slot(last_idx, last_valid,
                         SLOT_W'(NUM_SLOTS - 1))
             : cand;
    hit_now  = |(hit & slot_onehot);
  end

  life_timer #(
    .WIDTH   (LIFE_W),
    .TERMINAL(LIFE_W'(LIFE_CYCLES - 1))
  ) u_life (
    .clk  (clk),
    .rst_n(rst_n),
    .load (take),
    .en   (state == ST_SHOW),
    .count(life_cnt),
    .tc   (life_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      prime       <= 1'b0;
      draws       <= '0;
      last_valid  <= 1'b0;
      last_idx    <= '0;
      slot_idx    <= '0;
      slot_onehot <= '0;
      active      <= 1'b0;
      busy        <= 1'b0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DRAW;
            busy  <= 1'b1;
            prime <= 1'b1;
            draws <= '0;
          end
        end
        ST_DRAW: begin
          if (prime) begin
            prime <= 1'b0;
          end else if (take) begin
            slot_idx    <= pick;
            last_idx    <= pick;
            last_valid  <= 1'b1;
            slot_onehot <= ONE << pick;
            active      <= 1'b1;
            state       <= ST_SHOW;
          end else begin
            draws <= draws + 4'd1;
          end
        end
        ST_SHOW: begin
          if (hit_now || life_tc) begin
            hit_pulse   <= hit_now;
            miss_pulse  <= !hit_now;
            active      <= 1'b0;
            slot_onehot <= '0;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_slot_picker.sv
// Scoreboarded bench for mole_slot_picker.
// NUM_SLOTS=9, LIFE_CYCLES=4, MAX_DRAWS=8.
module tb_mole_slot_picker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] rand_in;
  logic        start;
  logic [8:0]  hit;
  logic        active;
  logic [3:0]  slot_idx;
  logic [8:0]  slot_onehot;
  logic        busy;
  logic        hit_pulse;
  logic        miss_pulse;

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] feed[$];
  logic [3:0] slot_q[$];
  logic       exp_q[$];

  always #5 clk = ~clk;

  mole_slot_picker #(
    .NUM_SLOTS  (9),
    .LIFE_CYCLES(4),
    .MAX_DRAWS  (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rand_in    (rand_in),
    .start      (start),
    .hit        (hit),
    .active     (active),
    .slot_idx   (slot_idx),
    .slot_onehot(slot_onehot),
    .busy       (busy),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input logic [3:0] exp_slot, input int exp_lat);
    int         k;
    logic [3:0] s;
    logic [8:0] exp_oh;
    slot_q.push_back(exp_slot);
    start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!active && k < 40) begin
      if (feed.size() > 0) rand_in = {8'($urandom), feed.pop_front()};
      else                 rand_in = 12'($urandom);
      step();
      k++;
    end
    feed.delete();
    s = slot_q.pop_front();
    vectors++;
    if (!active) begin
      $display("FAIL spawn_timeout: active=%0b after %0d cycles, want 1", active, k);
      miscompares++;
      return;
    end
    exp_oh = 9'd1 << s;
    vectors++;
    if (k !== exp_lat) begin
      $display("FAIL spawn_latency: got %0d want %0d", k, exp_lat);
      miscompares++;
    end
    vectors++;
    if (slot_idx !== s) begin
      $display("FAIL spawn_slot: got %0d want %0d", slot_idx, s);
      miscompares++;
    end
    vectors++;
    if (slot_onehot !== exp_oh || busy !== 1'b1) begin
      $display("FAIL spawn_onehot: got %b busy %b want %b busy 1", slot_onehot, busy, exp_oh);
      miscompares++;
    end
  endtask

  task automatic wait_end(input int exp_len);
    int   k;
    logic e;
    k = 0;
    while (!(hit_pulse || miss_pulse) && k < 20) begin
      step();
      k++;
    end
    e = exp_q.pop_front();
    vectors++;
    if (!(hit_pulse || miss_pulse)) begin
      $display("FAIL end_timeout: no pulse after %0d cycles", k);
      miscompares++;
      return;
    end
    vectors++;
    if (hit_pulse !== e || miss_pulse !== !e || active !== 1'b0) begin
      $display("FAIL end_kind: hit %b miss %b active %b want hit %b miss %b active 0",
               hit_pulse, miss_pulse, active, e, !e);
      miscompares++;
    end
    vectors++;
    if (k !== exp_len) begin
      $display("FAIL end_life: got %0d want %0d", k, exp_len);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    hit = '0;
    rand_in = '0;
    step();
    step();
    vectors++;
    if ({active, busy, hit_pulse, miss_pulse} !== 4'b0) begin
      $display("FAIL reset_flags: got %b want 0000", {active, busy, hit_pulse, miss_pulse});
      miscompares++;
    end
    vectors++;
    if (slot_idx !== 4'd0 || slot_onehot !== 9'd0) begin
      $display("FAIL reset_slot: got %0d/%b want 0/0", slot_idx, slot_onehot);
      miscompares++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_first_draw();
    feed = '{4'h3};
    spawn(4'd3, 2);
    exp_q.push_back(1'b0);
    wait_end(4);
    step();
    vectors++;
    if (miss_pulse !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL miss_one_cycle: miss %b busy %b want 0 0", miss_pulse, busy);
      miscompares++;
    end
  endtask

  task automatic test_rejections();
    feed = '{4'hF, 4'hA, 4'h5};
    spawn(4'd5, 4);
    exp_q.push_back(1'b0);
    wait_end(4);
    feed = '{4'h5, 4'h2};
    spawn(4'd2, 3);
  endtask

  task automatic test_hit();
    hit = 9'b000010000;
    step();
    hit = '0;
    vectors++;
    if (active !== 1'b1 || hit_pulse !== 1'b0) begin
      $display("FAIL hit_other: active %b hit_pulse %b want 1 0", active, hit_pulse);
      miscompares++;
    end
    hit = 9'b000000100;
    exp_q.push_back(1'b1);
    wait_end(1);
    hit = '0;
    step();
    vectors++;
    if (hit_pulse !== 1'b0) begin
      $display("FAIL hit_one_cycle: got %b want 0", hit_pulse);
      miscompares++;
    end
    feed = '{4'h7};
    spawn(4'd7, 2);
    step();
    step();
    step();
    vectors++;
    if (active !== 1'b1) begin
      $display("FAIL pre_expiry: active %b want 1", active);
      miscompares++;
    end
    hit = 9'b010000000;
    exp_q.push_back(1'b1);
    wait_end(1);
    hit = '0;
    step();
    vectors++;
    if (miss_pulse !== 1'b0 || hit_pulse !== 1'b0) begin
      $display("FAIL expiry_late: miss %b hit %b want 0 0", miss_pulse, hit_pulse);
      miscompares++;
    end
  endtask

  task automatic test_fallback();
    feed = '{4'h8};
    spawn(4'd8, 2);
    exp_q.push_back(1'b0);
    wait_end(4);
    for (int i = 0; i < 9; i++) feed.push_back(4'hF);
    spawn(4'd0, 10);
    exp_q.push_back(1'b0);
    wait_end(4);
  endtask

  task automatic test_reset_mid_show();
    int pulses;
    feed = '{4'h4};
    spawn(4'd4, 2);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if ({active, busy, hit_pulse, miss_pulse} !== 4'b0 || slot_onehot !== 9'd0) begin
      $display("FAIL rst_show: flags %b onehot %b want 0000 0",
               {active, busy, hit_pulse, miss_pulse}, slot_onehot);
      miscompares++;
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (hit_pulse || miss_pulse || busy) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      $display("FAIL rst_quiet: got %0d events want 0", pulses);
      miscompares++;
    end
    feed = '{4'h4};
    spawn(4'd4, 2);
    exp_q.push_back(1'b0);
    wait_end(4);
  endtask

  task automatic test_back_to_back();
    logic [3:0] prev_slot;
    logic       prev_busy;
    logic       prev_active;
    logic       seen_fall;
    int         idle_run;
    int         spawns;
    logic       e;
    prev_slot = 4'd4;
    prev_busy = 1'b0;
    prev_active = 1'b0;
    seen_fall = 1'b0;
    idle_run = 0;
    spawns = 0;
    start = 1'b1;
    for (int c = 0; c < 90; c++) begin
      rand_in = 12'($urandom);
      step();
      if (active && !prev_active) begin
        spawns++;
        vectors++;
        if (slot_idx == prev_slot || slot_idx > 4'd8 || slot_onehot !== (9'd1 << slot_idx)) begin
          $display("FAIL b2b_pick: slot %0d onehot %b prev %0d", slot_idx, slot_onehot, prev_slot);
          miscompares++;
        end
        prev_slot = slot_idx;
        exp_q.push_back(1'b0);
      end
      if (hit_pulse || miss_pulse) begin
        e = exp_q.pop_front();
        vectors++;
        if (miss_pulse !== !e || hit_pulse !== e) begin
          $display("FAIL b2b_kind: hit %b miss %b want hit %b", hit_pulse, miss_pulse, e);
          miscompares++;
        end
      end
      if (prev_busy && !busy) begin
        seen_fall = 1'b1;
        vectors++;
        if (!(hit_pulse || miss_pulse)) begin
          $display("FAIL b2b_busy_drop: busy fell without pulse");
          miscompares++;
        end
      end
      if (!busy) idle_run++;
      if (busy && !prev_busy && seen_fall) begin
        vectors++;
        if (idle_run !== 1) begin
          $display("FAIL b2b_idle_gap: got %0d want 1", idle_run);
          miscompares++;
        end
      end
      if (busy) idle_run = 0;
      prev_busy = busy;
      prev_active = active;
    end
    start = 1'b0;
    for (int c = 0; c < 30 && busy; c++) begin
      step();
      if (hit_pulse || miss_pulse) void'(exp_q.pop_front());
    end
    vectors++;
    if (spawns < 4 || exp_q.size() != 0 || busy) begin
      $display("FAIL b2b_total: spawns %0d pending %0d busy %b want >=4 0 0",
               spawns, exp_q.size(), busy);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_first_draw();
    test_rejections();
    test_hit();
    test_fallback();
    test_reset_mid_show();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
